// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, multi-cycle EX sequencing and branch flush
// for the 5-stage core, with saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int MC_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_is_mc,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int CW = $clog2(MC_LAT) + 1;
    localparam int unsigned INIT = (MC_LAT > 1) ? MC_LAT - 2 : 0;
    localparam logic [CW-1:0] CNT_INIT = CW'(INIT);
    localparam bit MC_EN = (MC_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        RUN,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mc_go;

    assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd);
    assign load_use = ex_memread && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    assign mc_go    = MC_EN && ex_is_mc;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        unique case (state)
            RUN: begin
                if (mc_go) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    state_nxt     = BUSY;
                    cnt_nxt       = CNT_INIT;
                end else if (ex_branch_taken) begin
                    // branch wins over load-use: the dependent op is squashed
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_nxt       = cnt - CW'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four instances with different MC_LAT/CNT_W
// share stimulus; each task checks the instance relevant to its scenario.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memrd, is_mc, br;

    int checks = 0;
    int errors = 0;

    logic pw3, ifw3, iff3, idw3, idb3, exb3, busy3;
    logic [15:0] sc3, fc3;
    logic pw1, ifw1, iff1, idw1, idb1, exb1, busy1;
    logic [15:0] sc1, fc1;
    logic pw4, ifw4, iff4, idw4, idb4, exb4, busy4;
    logic [15:0] sc4, fc4;
    logic pws, ifws, iffs, idws, idbs, exbs, busys;
    logic [3:0] scs, fcs;

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .arst_n(arst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .ex_rd(rd), .ex_memread(memrd), .ex_is_mc(is_mc),
        .ex_branch_taken(br),
        .pc_write(pw3), .if_id_write(ifw3), .if_id_flush(iff3),
        .id_ex_write(idw3), .id_ex_bubble(idb3), .ex_mem_bubble(exb3),
        .busy(busy3), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    hazard_ctrl #(.MC_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .arst_n(arst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .ex_rd(rd), .ex_memread(memrd), .ex_is_mc(is_mc),
        .ex_branch_taken(br),
        .pc_write(pw1), .if_id_write(ifw1), .if_id_flush(iff1),
        .id_ex_write(idw1), .id_ex_bubble(idb1), .ex_mem_bubble(exb1),
        .busy(busy1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_ctrl #(.MC_LAT(4), .CNT_W(16)) u4 (
        .clk(clk), .arst_n(arst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .ex_rd(rd), .ex_memread(memrd), .ex_is_mc(is_mc),
        .ex_branch_taken(br),
        .pc_write(pw4), .if_id_write(ifw4), .if_id_flush(iff4),
        .id_ex_write(idw4), .id_ex_bubble(idb4), .ex_mem_bubble(exb4),
        .busy(busy4), .stall_cnt(sc4), .flush_cnt(fc4)
    );

    hazard_ctrl #(.MC_LAT(3), .CNT_W(4)) us (
        .clk(clk), .arst_n(arst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .ex_rd(rd), .ex_memread(memrd), .ex_is_mc(is_mc),
        .ex_branch_taken(br),
        .pc_write(pws), .if_id_write(ifws), .if_id_flush(iffs),
        .id_ex_write(idws), .id_ex_bubble(idbs), .ex_mem_bubble(exbs),
        .busy(busys), .stall_cnt(scs), .flush_cnt(fcs)
    );

    task automatic clear_in();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0;
        memrd = 1'b0; is_mc = 1'b0; br = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        arst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        arst_n = 1'b0;
        #1;
        checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL rst_pc_write got %b exp 1", pw3); end
        checks++; if (ifw3 !== 1'b1) begin errors++; $display("FAIL rst_if_id_write got %b exp 1", ifw3); end
        checks++; if (idw3 !== 1'b1) begin errors++; $display("FAIL rst_id_ex_write got %b exp 1", idw3); end
        checks++; if ({iff3, idb3, exb3} !== 3'b000) begin errors++; $display("FAIL rst_bubbles got %b exp 000", {iff3, idb3, exb3}); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy3); end
        checks++; if (sc3 !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", sc3); end
        checks++; if (fc3 !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt got %0d exp 0", fc3); end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1;
        #1;
        checks++; if ({pw3, ifw3, idb3} !== 3'b001) begin errors++; $display("FAIL lu_stall got %b exp 001", {pw3, ifw3, idb3}); end
        checks++; if ({idw3, exb3, iff3} !== 3'b100) begin errors++; $display("FAIL lu_other got %b exp 100", {idw3, exb3, iff3}); end
        @(negedge clk);
        clear_in();
        #1;
        checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", pw3); end
        checks++; if (sc3 !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", sc3); end
    endtask

    task automatic test_x0_unused();
        memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; use1 = 1'b1;
        #1;
        checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL x0_no_stall got %b exp 1", pw3); end
        @(negedge clk);
        rd = 5'd7; rs1 = 5'd7; use1 = 1'b0;
        #1;
        checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL unused_no_stall got %b exp 1", pw3); end
        @(negedge clk);
        clear_in();
        #1;
        checks++; if (sc3 !== 16'd1) begin errors++; $display("FAIL x0_stall_cnt got %0d exp 1", sc3); end
    endtask

    task automatic test_multicycle();
        do_reset();
        is_mc = 1'b1;
        #1;
        checks++; if ({pw3, ifw3, idw3, exb3} !== 4'b0001) begin errors++; $display("FAIL mc_n_freeze got %b exp 0001", {pw3, ifw3, idw3, exb3}); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL mc_n_busy got %b exp 0", busy3); end
        checks++; if ({pw1, exb1} !== 2'b10) begin errors++; $display("FAIL mc1_n got %b exp 10", {pw1, exb1}); end
        @(negedge clk);
        br = 1'b1;
        #1;
        checks++; if ({busy3, pw3, exb3} !== 3'b101) begin errors++; $display("FAIL mc_n1 got %b exp 101", {busy3, pw3, exb3}); end
        checks++; if (iff3 !== 1'b0) begin errors++; $display("FAIL mc_busy_branch got %b exp 0", iff3); end
        checks++; if ({busy1, iff1} !== 2'b01) begin errors++; $display("FAIL mc1_n1 got %b exp 01", {busy1, iff1}); end
        @(negedge clk);
        br = 1'b0;
        #1;
        checks++; if ({busy3, pw3, exb3} !== 3'b110) begin errors++; $display("FAIL mc_n2_release got %b exp 110", {busy3, pw3, exb3}); end
        @(negedge clk);
        is_mc = 1'b0;
        #1;
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL mc_n3_busy got %b exp 0", busy3); end
        checks++; if (sc3 !== 16'd2) begin errors++; $display("FAIL mc_stall_cnt got %0d exp 2", sc3); end
        checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL mc1_stall_cnt got %0d exp 0", sc1); end
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        br = 1'b1; memrd = 1'b1; rd = 5'd3; rs1 = 5'd3; use1 = 1'b1;
        #1;
        checks++; if ({iff3, idb3, pw3, ifw3} !== 4'b1111) begin errors++; $display("FAIL br_outputs got %b exp 1111", {iff3, idb3, pw3, ifw3}); end
        @(negedge clk);
        clear_in();
        #1;
        checks++; if (fc3 !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got %0d exp 1", fc3); end
        checks++; if (sc3 !== 16'd0) begin errors++; $display("FAIL br_stall_cnt got %0d exp 0", sc3); end
    endtask

    task automatic test_back_to_back();
        br = 1'b1;
        @(negedge clk);
        @(negedge clk);
        br = 1'b0; memrd = 1'b1; rd = 5'd9; rs2 = 5'd9; use2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_in();
        #1;
        checks++; if (fc3 !== 16'd3) begin errors++; $display("FAIL b2b_flush_cnt got %0d exp 3", fc3); end
        checks++; if (sc3 !== 16'd2) begin errors++; $display("FAIL b2b_stall_cnt got %0d exp 2", sc3); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        is_mc = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({busy4, pw4} !== 2'b10) begin errors++; $display("FAIL mb_busy got %b exp 10", {busy4, pw4}); end
        checks++; if (sc4 !== 16'd1) begin errors++; $display("FAIL mb_stall_pre got %0d exp 1", sc4); end
        is_mc = 1'b0;
        arst_n = 1'b0;
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL mb_rst_busy got %b exp 0", busy4); end
        checks++; if ({sc4, fc4} !== 32'd0) begin errors++; $display("FAIL mb_rst_cnts got %0d/%0d exp 0/0", sc4, fc4); end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({busy4, pw4, exb4} !== 3'b010) begin errors++; $display("FAIL mb_after got %b exp 010", {busy4, pw4, exb4}); end
        checks++; if (sc4 !== 16'd0) begin errors++; $display("FAIL mb_after_stall got %0d exp 0", sc4); end
    endtask

    task automatic test_saturation();
        do_reset();
        memrd = 1'b1; rd = 5'd12; rs1 = 5'd12; use1 = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        checks++; if (scs !== 4'd15) begin errors++; $display("FAIL sat_stall_cnt got %0d exp 15", scs); end
        checks++; if (sc3 !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt got %0d exp 20", sc3); end
        checks++; if (pws !== 1'b0) begin errors++; $display("FAIL sat_still_stall got %b exp 0", pws); end
        clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_load_use();
        test_x0_unused();
        test_multicycle();
        test_branch_vs_load_use();
        test_back_to_back();
        test_reset_mid_busy();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
